// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per channel a 2-flop synchroniser, debounce
// counter, registered press/release pulses, optional auto-repeat and optional toggle latch.
module button_conditioner #(
    parameter int              N_CH            = 3,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              REPEAT_DELAY    = 25000000,
    parameter int              REPEAT_PERIOD   = 10000000,
    parameter logic [N_CH-1:0] TOGGLE_MASK     = 3'b100,
    parameter logic [N_CH-1:0] REPEAT_MASK     = 3'b001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] toggle_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_SAT  = '1;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam bit RPT_EN = REPEAT_MASK[gi];
            localparam bit TOG_EN = TOGGLE_MASK[gi];

            logic [1:0]       sync_q;
            logic             level_q, level_d;
            logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
            logic             press_q, press_d;
            logic             rel_q, rel_d;
            logic             tog_q, tog_d;
            logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
            logic             rpt_phase_q, rpt_phase_d;
            logic             accept, rise, fall, rpt_hit;

            always_comb begin
                db_cnt_d    = '0;
                level_d     = level_q;
                accept      = 1'b0;
                rpt_cnt_d   = rpt_cnt_q;
                rpt_phase_d = rpt_phase_q;
                rpt_hit     = 1'b0;

                if (sync_q[1] != level_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        accept  = 1'b1;
                        level_d = sync_q[1];
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end

                rise = accept & sync_q[1];
                fall = accept & ~sync_q[1];

                // Phase 0 waits for the initial delay, phase 1 for each repeat period.
                // A falling edge in the same cycle suppresses any due repeat.
                if (rise) begin
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
                end else if (level_q && !fall) begin
                    if ((!rpt_phase_q && rpt_cnt_q == RD_LAST) ||
                        ( rpt_phase_q && rpt_cnt_q == RP_LAST)) begin
                        rpt_hit     = RPT_EN;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else if (rpt_cnt_q != RPT_SAT) begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end

                press_d = rise | rpt_hit;
                rel_d   = fall;
                tog_d   = TOG_EN ? (tog_q ^ rise) : 1'b0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q      <= '0;
                    level_q     <= 1'b0;
                    db_cnt_q    <= '0;
                    press_q     <= 1'b0;
                    rel_q       <= 1'b0;
                    tog_q       <= 1'b0;
                    rpt_cnt_q   <= '0;
                    rpt_phase_q <= 1'b0;
                end else begin
                    sync_q      <= {sync_q[0], btn_raw_i[gi]};
                    level_q     <= level_d;
                    db_cnt_q    <= db_cnt_d;
                    press_q     <= press_d;
                    rel_q       <= rel_d;
                    tog_q       <= tog_d;
                    rpt_cnt_q   <= rpt_cnt_d;
                    rpt_phase_q <= rpt_phase_d;
                end
            end

            assign level_o[gi]   = level_q;
            assign press_o[gi]   = press_q;
            assign release_o[gi] = rel_q;
            assign toggle_o[gi]  = tog_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues hand-computed events,
// a negedge monitor pops and compares whenever press or release is presented.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] level, press, rel, tog;

    button_conditioner #(
        .N_CH(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
        .TOGGLE_MASK(3'b100), .REPEAT_MASK(3'b001)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw_i(btn_raw),
        .level_o(level), .press_o(press), .release_o(rel), .toggle_o(tog)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] l;
        logic [2:0] t;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, req);
        end
    endtask

    task automatic checki(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic void expect_ev(input int c, input logic [2:0] p, input logic [2:0] r,
                                      input logic [2:0] l, input logic [2:0] t);
        ev_t e;
        e.c = c; e.p = p; e.r = r; e.l = l; e.t = t;
        exp_q.push_back(e);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every presented press/release is matched against the queue head.
    always @(negedge clk) begin
        ev_t e;
        check3("unmasked_toggle", {1'b0, tog[1:0]}, 3'b000);
        if ((press | rel) != 3'b000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event at edge %0d: press=%b release=%b, expected none",
                         cyc, press, rel);
            end else begin
                e = exp_q.pop_front();
                checki("event_edge", cyc, e.c);
                check3("event_press", press, e.p);
                check3("event_release", rel, e.r);
                check3("event_level", level, e.l);
                check3("event_toggle", tog, e.t);
                $display("event edge=%0d press=%b release=%b level=%b toggle=%b",
                         cyc, press, rel, level, tog);
            end
        end
    end

    initial begin
        int         c, p, q;
        logic [7:0] bounce;

        repeat (3) @(negedge clk);
        check3("reset_level", level, 3'b000);
        check3("reset_press", press, 3'b000);
        check3("reset_release", rel, 3'b000);
        check3("reset_toggle", tog, 3'b000);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check3("idle_level", level, 3'b000);

        // 1: clean press and release on channel 1
        c = cyc;
        btn_raw[1] = 1'b1;
        expect_ev(c + 6, 3'b010, 3'b000, 3'b010, 3'b000);
        wait_until(c + 20);
        btn_raw[1] = 1'b0;
        expect_ev(c + 26, 3'b000, 3'b010, 3'b000, 3'b000);
        wait_until(c + 40);

        // 2: bounce 1,1,1,0,1,1,1,0 then steady 1
        c = cyc;
        bounce = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            btn_raw[1] = bounce[i];
            @(negedge clk);
        end
        btn_raw[1] = 1'b1;
        expect_ev(c + 14, 3'b010, 3'b000, 3'b010, 3'b000);
        wait_until(c + 13);
        check3("bounce_level_low", level, 3'b000);
        wait_until(c + 24);
        btn_raw[1] = 1'b0;
        expect_ev(c + 30, 3'b000, 3'b010, 3'b000, 3'b000);
        wait_until(c + 40);

        // 3: auto-repeat on channel 0, level falls at P+30
        c = cyc;
        p = c + 6;
        btn_raw[0] = 1'b1;
        expect_ev(p, 3'b001, 3'b000, 3'b001, 3'b000);
        for (int k = 10; k <= 28; k += 3)
            expect_ev(p + k, 3'b001, 3'b000, 3'b001, 3'b000);
        wait_until(p + 24);
        btn_raw[0] = 1'b0;
        expect_ev(p + 30, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_until(p + 29);
        check3("repeat_level_held", level, 3'b001);
        wait_until(p + 45);

        // 4: toggle on channel 2, two press/release cycles
        c = cyc;
        btn_raw[2] = 1'b1;
        expect_ev(c + 6, 3'b100, 3'b000, 3'b100, 3'b100);
        wait_until(c + 8);
        check3("toggle_after_first", tog, 3'b100);
        wait_until(c + 10);
        btn_raw[2] = 1'b0;
        expect_ev(c + 16, 3'b000, 3'b100, 3'b000, 3'b100);
        wait_until(c + 20);
        btn_raw[2] = 1'b1;
        expect_ev(c + 26, 3'b100, 3'b000, 3'b100, 3'b000);
        wait_until(c + 30);
        btn_raw[2] = 1'b0;
        expect_ev(c + 36, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_until(c + 50);

        // 5: all channels together
        c = cyc;
        btn_raw = 3'b111;
        expect_ev(c + 6, 3'b111, 3'b000, 3'b111, 3'b100);
        wait_until(c + 8);
        btn_raw = 3'b000;
        expect_ev(c + 14, 3'b000, 3'b111, 3'b000, 3'b100);
        wait_until(c + 30);

        // 6: reset mid-repeat on channel 0
        c = cyc;
        p = c + 6;
        btn_raw[0] = 1'b1;
        expect_ev(p, 3'b001, 3'b000, 3'b001, 3'b100);
        expect_ev(p + 10, 3'b001, 3'b000, 3'b001, 3'b100);
        wait_until(p + 11);
        rst = 1'b1;
        #1;
        check3("rst_level", level, 3'b000);
        check3("rst_press", press, 3'b000);
        check3("rst_release", rel, 3'b000);
        check3("rst_toggle", tog, 3'b000);
        wait_until(p + 14);
        check3("rst_hold_level", level, 3'b000);
        rst = 1'b0;
        q = p + 20;
        expect_ev(q, 3'b001, 3'b000, 3'b001, 3'b000);
        expect_ev(q + 10, 3'b001, 3'b000, 3'b001, 3'b000);
        expect_ev(q + 13, 3'b001, 3'b000, 3'b001, 3'b000);
        expect_ev(q + 16, 3'b001, 3'b000, 3'b001, 3'b000);
        wait_until(q + 11);
        btn_raw[0] = 1'b0;
        expect_ev(q + 17, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_until(q + 30);

        checki("pending_events", exp_q.size(), 0);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            $display("missing event: edge=%0d press=%b release=%b", e.c, e.p, e.r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
